pe_row_sequencer: RTL and testbench
===================================

# pe_row_sequencer

Job-level controller for one row of `NPE` PE columns, each containing a DataPathController. It accepts a configuration command over a rdy/ack handshake and broadcasts that `Conf` to all PEs. It then drives the shared `Inst` word (dval/start/reset/next/stall) through `npass` consecutive passes, collects each PE's `confEnd`, and reports completion over a second rdy/ack handshake.

## Interface
Parameters:
- `NPE`, default 4: number of PE columns driven by the broadcast `Inst`.
- `PASSW`, default 8: width of the pass count and the pass index.
- `CYCW`, default 24: width of the busy-cycle performance counter.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `cmd_rdy`  in  1  command valid.
- `cmd_ack`  out  1  command accepted; transfer occurs when `cmd_rdy && cmd_ack`.
- `i_cmd_conf`  in  `Conf`  PE configuration for the job.
- `i_cmd_npass`  in  PASSW  number of passes; 0 is treated as 1.
- `i_stall`  in  1  global stall, e.g. buffer underflow.
- `i_abort`  in  1  abort the current job.
- `i_confEnd`  in  NPE  per-PE `DPstatus.confEnd`.
- `o_PEconf`  out  `Conf`  registered broadcast configuration.
- `o_PEinst`  out  `Inst`  broadcast instruction.
- `done_rdy`  out  1  job finished.
- `done_ack`  in  1  completion consumed.
- `o_aborted`  out  1  valid while `done_rdy`; 1 means the job was aborted.
- `o_pass_idx`  out  PASSW  current pass, 0-based.
- `o_cycles`  out  CYCW  cycles spent in RUN for the last or current job.
- `o_busy`  out  1  state is neither IDLE nor DONE.

## Operation
States: IDLE, START, RUN, NEXT, ABORT, DONE.
- **IDLE**
  - `cmd_ack=1`.
  - On transfer: latch `o_PEconf`, latch `npass_r = max(i_cmd_npass,1)`, clear `o_pass_idx`, the end mask and `o_cycles`, then go to START.
- **START** (one cycle)
  - `o_PEinst = {dval:1, start:1, reset:1}`, which clears the PE loop counters and moves each PE from IDLE to INIT.
  - Go to RUN.
- **RUN**
  - `o_PEinst.dval=1`; `o_PEinst.stall=i_stall`, combinational pass-through.
  - `o_cycles` increments each cycle and saturates at all-ones.
  - `end_mask |= i_confEnd`.
  - When `end_mask` is all ones:
    - if `o_pass_idx == npass_r-1`, go to DONE;
    - otherwise go to NEXT.
- **NEXT** (one cycle)
  - `o_PEinst = {dval:1, start:1, next:1}`.
  - `o_pass_idx++`, clear `end_mask`.
  - Go to RUN.
- **ABORT** (one cycle)
  - Entered from START, RUN or NEXT when `i_abort=1`.
  - `o_PEinst = {dval:1, reset:1}`.
  - Set the aborted flag and go to DONE.
- **DONE**
  - `done_rdy=1` and `o_aborted` is held.
  - On `done_ack`, go to IDLE and clear the aborted flag.

Boundary rules:
- `i_abort` has priority over the end-mask completion and over the START/NEXT transitions in the same cycle.
- `i_abort` is ignored in IDLE and DONE.
- `i_confEnd` is ignored outside RUN.
- The end mask is sticky: PEs may finish in different cycles.
- `cmd_rdy` is ignored, with `cmd_ack=0`, in every state except IDLE.
- `done_ack` is ignored while `done_rdy=0`.
- `o_pass_idx` never wraps, because `npass_r <= 2^PASSW-1`.
- `i_stall` is forwarded only in RUN; it is 0 in START, NEXT and ABORT.

## Timing
- Reset values:
  - state IDLE; `cmd_ack=1`; `done_rdy=0`.
  - `o_PEinst` all fields 0; `o_PEconf='0`.
  - `o_pass_idx=0`, `o_cycles=0`, `o_aborted=0`, `o_busy=0`.
- `o_PEinst`, `cmd_ack`, `done_rdy` and `o_busy` are decoded combinationally from the registered state. The only exception is `stall`, which is combinational from `i_stall`.
- For a command accepted at cycle t: START at t+1, first RUN cycle at t+2.
- Completion:
  - The last `confEnd` bit arrives at cycle u. The next state is NEXT at u+1, or DONE at u+1.
  - After NEXT at u+1, RUN resumes at u+2.
  - From DONE, `done_ack` at cycle d means IDLE at d+1, and a new command can be accepted at d+1.
- Abort: `i_abort` at cycle a means ABORT at a+1 and DONE at a+2.
- `o_cycles` and `o_pass_idx` are registered and update one cycle after the event.

## Structure
- `PECtlCfg` package:
  - add `SeqCmd` packed struct `{Conf conf; logic [PASSW-1:0] npass}`;
  - add `localparam` defaults for `NPE`.
- The state enum stays local to the module.
- Flops use the team's async-reset flop macros.
- No sub-module: the pass and cycle counters are plain registers.

## Test plan
- **Single pass.** Command with npass=1; all 4 `confEnd` bits rise together 20 cycles after RUN.
  - START pulse `{dval,start,reset}` at t+1; DONE at u+1.
  - `o_aborted=0`, `o_cycles=21`.
- **Staggered ends, 3 passes.**
  - In each pass, PE0–PE3 raise `confEnd` at cycles 5, 9, 9 and 14.
  - Exactly two NEXT pulses are issued, each 1 cycle after the PE3 end.
  - `o_pass_idx` goes 0→1→2; DONE after the third pass.
- **npass=0.** Behaves exactly as npass=1.
- **Stall.** `i_stall` held high for 10 cycles in RUN.
  - `o_PEinst.stall` mirrors it with the same timing.
  - `o_cycles` still counts; no state change.
- **Abort in the same cycle as the final end.**
  - `i_abort=1` while the last `confEnd` bit arrives: ABORT `{dval,reset}`, then DONE with `o_aborted=1`.
  - `done_ack` returns the block to IDLE with `cmd_ack=1`.
- **Back-pressure and reset.**
  - `cmd_rdy` held high during RUN: `cmd_ack` stays 0, so there is no second latch.
  - `i_rst_n` asserted mid-RUN: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/pe_row_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_row_sequencer_pkg
//  Description : Shared types for the PE-row job controller. Holds the PE
//                configuration word, the broadcast instruction word, the
//                sequencer command bundle and the default row geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package pe_row_sequencer_pkg;

    // Default row geometry
    localparam int NPE_DEFAULT   = 4;
    localparam int PASSW_DEFAULT = 8;
    localparam int CYCW_DEFAULT  = 24;

    // Per-job PE configuration, broadcast to every column
    typedef struct packed {
        logic [3:0] mode;
        logic [5:0] loop_lim;
        logic [5:0] stride;
    } Conf;

    // Broadcast instruction word consumed by each DataPathController
    typedef struct packed {
        logic dval;
        logic start;
        logic reset;
        logic next;
        logic stall;
    } Inst;

    // Command bundle as seen on the configuration handshake
    typedef struct packed {
        Conf                      conf;
        logic [PASSW_DEFAULT-1:0] npass;
    } SeqCmd;

endpackage
`default_nettype wire

// File: rtl/pe_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pe_row_sequencer
//  Description : Job-level controller for one row of NPE PE columns.
//                Accepts a configuration command, broadcasts Conf, steps the
//                shared Inst word through npass passes while collecting each
//                PE's confEnd, and reports completion on a done handshake.
//  Ports       : i_clk / i_rst_n      clock, async active-low reset
//                cmd_rdy / cmd_ack    command handshake (i_cmd_conf, i_cmd_npass)
//                i_stall, i_abort     global stall, job abort
//                i_confEnd            per-PE end-of-configuration flags
//                o_PEconf, o_PEinst   broadcast configuration / instruction
//                done_rdy / done_ack  completion handshake (o_aborted)
//                o_pass_idx, o_cycles, o_busy  status
//  Revision    : 1.0  initial release
// ============================================================================
module pe_row_sequencer
    import pe_row_sequencer_pkg::*;
#(
    parameter int NPE   = NPE_DEFAULT,
    parameter int PASSW = PASSW_DEFAULT,
    parameter int CYCW  = CYCW_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             cmd_rdy,
    output logic             cmd_ack,
    input  Conf              i_cmd_conf,
    input  logic [PASSW-1:0] i_cmd_npass,
    input  logic             i_stall,
    input  logic             i_abort,
    input  logic [NPE-1:0]   i_confEnd,
    output Conf              o_PEconf,
    output Inst              o_PEinst,
    output logic             done_rdy,
    input  logic             done_ack,
    output logic             o_aborted,
    output logic [PASSW-1:0] o_pass_idx,
    output logic [CYCW-1:0]  o_cycles,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_NEXT  = 3'd3,
        S_ABORT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    Conf              r_conf;
    logic [PASSW-1:0] r_npass;
    logic [PASSW-1:0] r_pass_idx;
    logic [NPE-1:0]   r_end_mask;
    logic [CYCW-1:0]  r_cycles;
    logic             r_aborted;

    // The current cycle's confEnd bits count toward completion immediately,
    // so the pass ends on the cycle the last PE reports.
    logic [NPE-1:0]   w_end_mask_nxt;
    logic             w_all_end;
    logic             w_last_pass;

    assign w_end_mask_nxt = r_end_mask | i_confEnd;
    assign w_all_end      = &w_end_mask_nxt;
    // r_npass is never 0, so the subtraction cannot underflow.
    assign w_last_pass    = (r_pass_idx == (r_npass - PASSW'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_conf     <= '0;
            r_npass    <= PASSW'(1);
            r_pass_idx <= '0;
            r_end_mask <= '0;
            r_cycles   <= '0;
            r_aborted  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_rdy) begin
                        r_conf     <= i_cmd_conf;
                        r_npass    <= (i_cmd_npass == '0) ? PASSW'(1) : i_cmd_npass;
                        r_pass_idx <= '0;
                        r_end_mask <= '0;
                        r_cycles   <= '0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_state <= i_abort ? S_ABORT : S_RUN;
                end
                S_RUN: begin
                    if (~&r_cycles) begin
                        r_cycles <= r_cycles + CYCW'(1);
                    end
                    // Abort wins over a pass completing in the same cycle.
                    if (i_abort) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_end_mask <= w_end_mask_nxt;
                        if (w_all_end) begin
                            r_state <= w_last_pass ? S_DONE : S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (i_abort) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_pass_idx <= r_pass_idx + PASSW'(1);
                        r_end_mask <= '0;
                        r_state    <= S_RUN;
                    end
                end
                S_ABORT: begin
                    r_aborted <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (done_ack) begin
                        r_aborted <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Instruction decode from the registered state; stall alone is a
    // combinational pass-through and only while running.
    always_comb begin
        o_PEinst = '0;
        case (r_state)
            S_START: begin
                o_PEinst.dval  = 1'b1;
                o_PEinst.start = 1'b1;
                o_PEinst.reset = 1'b1;
            end
            S_RUN: begin
                o_PEinst.dval  = 1'b1;
                o_PEinst.stall = i_stall;
            end
            S_NEXT: begin
                o_PEinst.dval  = 1'b1;
                o_PEinst.start = 1'b1;
                o_PEinst.next  = 1'b1;
            end
            S_ABORT: begin
                o_PEinst.dval  = 1'b1;
                o_PEinst.reset = 1'b1;
            end
            default: begin
                o_PEinst = '0;
            end
        endcase
    end

    assign cmd_ack    = (r_state == S_IDLE);
    assign done_rdy   = (r_state == S_DONE);
    assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_PEconf   = r_conf;
    assign o_aborted  = r_aborted;
    assign o_pass_idx = r_pass_idx;
    assign o_cycles   = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pe_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_row_sequencer
//  Description : Self-checking bench for pe_row_sequencer. Each job is
//                described by per-pass PE end times; the expected instruction
//                stream, pass index, cycle count and completion are derived
//                from those times with plain arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pe_row_sequencer;
    import pe_row_sequencer_pkg::*;

    localparam int NPE     = 4;
    localparam int PASSW   = 8;
    localparam int CYCW    = 6;
    localparam int CYC_MAX = (1 << CYCW) - 1;
    localparam int CONFW   = $bits(Conf);

    // {dval,start,reset,next,stall}
    localparam logic [4:0] I_NONE  = 5'b00000;
    localparam logic [4:0] I_START = 5'b11100;
    localparam logic [4:0] I_NEXT  = 5'b11010;
    localparam logic [4:0] I_ABORT = 5'b10100;

    logic             i_clk    = 1'b0;
    logic             i_rst_n  = 1'b0;
    logic             cmd_rdy  = 1'b0;
    logic             i_stall  = 1'b0;
    logic             i_abort  = 1'b0;
    logic             done_ack = 1'b0;
    logic             cmd_ack, done_rdy, o_aborted, o_busy;
    Conf              i_cmd_conf = '0;
    Conf              o_PEconf;
    Inst              o_PEinst;
    logic [PASSW-1:0] i_cmd_npass = '0;
    logic [PASSW-1:0] o_pass_idx;
    logic [NPE-1:0]   i_confEnd = '0;
    logic [CYCW-1:0]  o_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int end_t [0:15][0:NPE-1];
    int m_pass = 0;
    int m_runs = 0;
    bit m_ab   = 1'b0;

    pe_row_sequencer #(.NPE(NPE), .PASSW(PASSW), .CYCW(CYCW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .cmd_rdy     (cmd_rdy),
        .cmd_ack     (cmd_ack),
        .i_cmd_conf  (i_cmd_conf),
        .i_cmd_npass (i_cmd_npass),
        .i_stall     (i_stall),
        .i_abort     (i_abort),
        .i_confEnd   (i_confEnd),
        .o_PEconf    (o_PEconf),
        .o_PEinst    (o_PEinst),
        .done_rdy    (done_rdy),
        .done_ack    (done_ack),
        .o_aborted   (o_aborted),
        .o_pass_idx  (o_pass_idx),
        .o_cycles    (o_cycles),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [4:0] inst, input logic ack,
                            input logic done, input logic busy);
        int ec;
        ec = (m_runs > CYC_MAX) ? CYC_MAX : m_runs;
        chk({tag, "/inst"},    32'(o_PEinst),   32'(inst));
        chk({tag, "/ack"},     32'(cmd_ack),    32'(ack));
        chk({tag, "/done"},    32'(done_rdy),   32'(done));
        chk({tag, "/busy"},    32'(o_busy),     32'(busy));
        chk({tag, "/pass"},    32'(o_pass_idx), 32'(m_pass));
        chk({tag, "/cycles"},  32'(o_cycles),   32'(ec));
        chk({tag, "/aborted"}, 32'(o_aborted),  32'(m_ab));
    endtask

    task automatic set_ends(input int p, input int a, input int b, input int c, input int d);
        end_t[p][0] = a; end_t[p][1] = b; end_t[p][2] = c; end_t[p][3] = d;
    endtask

    task automatic fill_random();
        for (int p = 0; p < 16; p++)
            for (int i = 0; i < NPE; i++)
                end_t[p][i] = int'($urandom_range(0, 10));
    endtask

    // One complete job. abort_at / reset_at / stall window are indices into
    // the job's RUN cycles counted across all passes (-1 disables).
    task automatic do_job(input int npass_cmd, input int abort_at, input int stall_from,
                          input int stall_len, input bit hold_rdy, input int reset_at);
        int n, len, g, w;
        Conf conf;
        logic [NPE-1:0] ce;
        bit aborted;
        n = (npass_cmd == 0) ? 1 : npass_cmd;
        conf = CONFW'($urandom);
        g = 0;
        aborted = 1'b0;

        // Command transfer in IDLE
        @(posedge i_clk); #1;
        cmd_rdy = 1'b1; i_cmd_conf = conf; i_cmd_npass = PASSW'(npass_cmd);
        i_stall = 1'($urandom);
        @(negedge i_clk);
        chk_outs("xfer", I_NONE, 1'b1, 1'b0, 1'b0);
        m_pass = 0; m_runs = 0;

        // START
        @(posedge i_clk); #1;
        cmd_rdy = hold_rdy; i_cmd_conf = ~conf; i_cmd_npass = PASSW'($urandom);
        i_stall = 1'($urandom);
        @(negedge i_clk);
        chk_outs("start", I_START, 1'b0, 1'b0, 1'b1);
        chk("start/conf", 32'(o_PEconf), 32'(conf));

        for (int p = 0; p < n && !aborted; p++) begin
            len = 0;
            for (int i = 0; i < NPE; i++)
                if (end_t[p][i] + 1 > len) len = end_t[p][i] + 1;
            for (int k = 0; k < len; k++) begin
                @(posedge i_clk); #1;
                for (int i = 0; i < NPE; i++) ce[i] = (k == end_t[p][i]);
                i_confEnd = ce;
                i_stall   = (g >= stall_from) && (g < stall_from + stall_len);
                i_abort   = (g == abort_at);
                if (g == reset_at) begin
                    i_rst_n = 1'b0;
                    #1;
                    m_pass = 0; m_runs = 0; m_ab = 1'b0;
                    chk_outs("reset_mid", I_NONE, 1'b1, 1'b0, 1'b0);
                    chk("reset_mid/conf", 32'(o_PEconf), 32'(0));
                    @(posedge i_clk); #1;
                    i_rst_n = 1'b1; i_confEnd = '0; i_stall = 1'b0; i_abort = 1'b0;
                    cmd_rdy = 1'b0;
                    @(negedge i_clk);
                    chk_outs("after_reset", I_NONE, 1'b1, 1'b0, 1'b0);
                    return;
                end
                @(negedge i_clk);
                chk_outs("run", {4'b1000, i_stall}, 1'b0, 1'b0, 1'b1);
                m_runs++;
                if (g == abort_at) begin
                    aborted = 1'b1;
                    g++;
                    break;
                end
                g++;
            end
            if (!aborted && p < n - 1) begin
                @(posedge i_clk); #1;
                i_confEnd = '1; i_stall = 1'($urandom); i_abort = 1'b0;
                @(negedge i_clk);
                chk_outs("next", I_NEXT, 1'b0, 1'b0, 1'b1);
                m_pass++;
            end
        end

        if (aborted) begin
            @(posedge i_clk); #1;
            i_confEnd = '1; i_stall = 1'($urandom); i_abort = 1'b0;
            @(negedge i_clk);
            chk_outs("abort", I_ABORT, 1'b0, 1'b0, 1'b1);
            m_ab = 1'b1;
        end

        // DONE, with a few un-acknowledged cycles first
        w = int'($urandom_range(0, 2));
        for (int j = 0; j <= w; j++) begin
            @(posedge i_clk); #1;
            cmd_rdy = 1'b0; i_confEnd = '1; i_abort = 1'($urandom);
            i_stall = 1'($urandom); done_ack = (j == w);
            @(negedge i_clk);
            chk_outs("done", I_NONE, 1'b0, 1'b1, 1'b0);
            chk("done/conf", 32'(o_PEconf), 32'(conf));
        end
        m_ab = 1'b0;

        @(posedge i_clk); #1;
        done_ack = 1'b0; i_confEnd = '0; i_abort = 1'b0; i_stall = 1'b0;
        @(negedge i_clk);
        chk_outs("idle", I_NONE, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int n, ab, sf, sl;

        // Reset state
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk_outs("reset", I_NONE, 1'b1, 1'b0, 1'b0);
        chk("reset/conf", 32'(o_PEconf), 32'(0));
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk_outs("post_reset", I_NONE, 1'b1, 1'b0, 1'b0);

        // Single pass, all ends together 20 cycles into RUN
        set_ends(0, 20, 20, 20, 20);
        do_job(1, -1, -1, 0, 1'b0, -1);
        chk("single/cycles_final", 32'(o_cycles), 32'd21);

        // Staggered ends, three passes
        for (int p = 0; p < 3; p++) set_ends(p, 5, 9, 9, 14);
        do_job(3, -1, -1, 0, 1'b0, -1);
        chk("stagger/pass_final", 32'(o_pass_idx), 32'd2);
        chk("stagger/cycles_final", 32'(o_cycles), 32'd45);

        // npass = 0 behaves as one pass
        fill_random();
        do_job(0, -1, -1, 0, 1'b0, -1);
        chk("npass0/pass_final", 32'(o_pass_idx), 32'd0);

        // Stall held for 10 RUN cycles
        set_ends(0, 25, 25, 25, 25);
        do_job(1, -1, 5, 10, 1'b0, -1);
        chk("stall/cycles_final", 32'(o_cycles), 32'd26);

        // Abort in the same cycle as the final end of the last pass
        set_ends(0, 3, 6, 2, 8);
        set_ends(1, 4, 8, 1, 0);
        do_job(2, 17, -1, 0, 1'b0, -1);

        // Command back-pressure while busy
        fill_random();
        do_job(2, -1, -1, 0, 1'b1, -1);

        // Cycle counter saturation
        set_ends(0, 70, 70, 70, 70);
        do_job(1, -1, -1, 0, 1'b0, -1);
        chk("sat/cycles_final", 32'(o_cycles), 32'(CYC_MAX));

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            n  = int'($urandom_range(0, 3));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            sf = int'($urandom_range(0, 15));
            sl = int'($urandom_range(0, 8));
            fill_random();
            do_job(n, ab, sf, sl, 1'($urandom), -1);
        end

        // Reset asserted mid-RUN, then a normal job
        set_ends(0, 12, 12, 12, 12);
        do_job(1, -1, -1, 0, 1'b0, 6);
        fill_random();
        do_job(2, -1, 2, 4, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
